xalu_ise_issue: RTL and testbench
=================================

// Module: xalu_ise_issue
// PURPOSE
//  Core-side issue/writeback controller for the custom-0..3 ISE ALU port.
//  - Accepts a decoded custom instruction plus rs1/rs2 values from the core pipeline.
//  - Drives the ISE request bus: ise_val, ise_fn, ise_imm, ise_in1, ise_in2.
//  - Collects ise_oval/ise_out and returns a registered writeback or an illegal-instruction response.
// PARAMETERS
//  MAX_WAIT   4   cycles in ISSUE without ise_oval before the op is declared illegal (>=1)
//  CNT_W      32  width of perf counters (used only with XALU_ISE_PERF_EN)
// PORTS
//  ise_clk     in   1   single clock, rising edge
//  ise_rst     in   1   synchronous, active-low reset
//  req_val     in   1   core request valid
//  req_rdy     out  1   controller can accept a request
//  req_instr   in   32  full RISC-V instruction word
//  req_rs1     in   32  rs1 operand value
//  req_rs2     in   32  rs2 operand value
//  rsp_val     out  1   writeback response valid
//  rsp_rdy     in   1   core accepts response
//  rsp_rd      out  5   destination register index (instr[11:7])
//  rsp_data    out  32  result; 0 when rsp_ill=1
//  rsp_ill     out  1   illegal instruction: non-custom opcode or ISE timeout
//  ise_val     out  1   request valid to ISE
//  ise_fn      out  5   {funct3 = instr[14:12], custom index 2'b00..2'b11}
//  ise_imm     out  7   funct7 = instr[31:25]
//  ise_in1     out  32  latched rs1
//  ise_in2     out  32  latched rs2
//  ise_oval    in   1   ISE result valid (combinational in the same cycle as ise_val)
//  ise_out     in   32  ISE result
// BEHAVIOUR
//  - States: IDLE, ISSUE, RESP. All outputs are registered, except req_rdy.
//  - Reset (ise_rst=0 at a clock edge), from any state:
//    - next state IDLE; any in-flight op is dropped with no response.
//    - rsp_val=0, ise_val=0, rsp_ill=0; rsp_data, rsp_rd, ise_fn, ise_imm, ise_in1, ise_in2 all 0.
//  - req_rdy = (state==IDLE) | (state==RESP & rsp_rdy).
//  - Accept (req_val & req_rdy):
//    - latch operands, rd, fn, imm.
//    - opcode custom-0/1/2/3 (7'h0B/2B/5B/7B) -> ISSUE, ise_val=1 next cycle.
//    - any other opcode -> RESP directly with rsp_ill=1, rsp_data=0; ise_val is never raised.
//  - ISSUE:
//    - ise_val=1; operands held stable; wait counter counts cycles in ISSUE.
//    - ise_oval=1 -> capture ise_out into rsp_data, rsp_ill=0, ise_val=0 next cycle, -> RESP.
//    - no ise_oval after MAX_WAIT cycles in ISSUE -> rsp_ill=1, rsp_data=0, ise_val=0, -> RESP.
//    - ise_oval on the final wait cycle wins over timeout.
//  - Latency: accept at edge N -> ise_val high from N+1 -> rsp_val high from N+2, given a same-cycle oval.
//  - RESP:
//    - rsp_val=1; rsp_* held stable until rsp_rdy.
//    - rsp_rdy without a new request -> IDLE, rsp_val=0.
//    - rsp_rdy with req_val in the same cycle -> back-to-back accept; next state per the new opcode.
//  - ise_oval outside ISSUE is ignored.
//  - rd=x0: response is still produced; the core discards it.
// CONFIGURATION
//  - XALU_ISE_PERF_EN defined: adds outputs perf_ops[CNT_W] and perf_ill[CNT_W].
//    - perf_ops increments on each successful ISE completion; perf_ill on each illegal response.
//    - both cleared by reset; both wrap modulo 2^CNT_W.
//  - XALU_ISE_PERF_EN undefined: no counters, no perf ports; behaviour otherwise identical.
// STRUCTURE
//  - Shared package xalu_ise_pkg:
//    - CUSTOM_0..3 2-bit indices.
//    - OPC_CUSTOM_0..3 7-bit opcodes.
//    - state encoding localparams.
//  - Sub-module xalu_ise_dec (combinational): instr -> {is_custom, fn[4:0], imm[6:0], rd[4:0]}.
//  - This file holds the FSM, operand/result registers, wait counter and perf counters.
// TESTING
//  - Happy path: instr=32'h4A00050B (custom-0, funct7=7'h25, rd=10), rs1=32'h12345678; stub ISE gives oval=1, out=32'hDEADBEEF
//    -> ise_fn=5'b00000, ise_imm=7'h25, ise_in1=32'h12345678; rsp_rd=10, rsp_data=32'hDEADBEEF, rsp_ill=0 at N+2.
//  - Non-custom: instr=32'h00B50533 (ADD) -> ise_val never 1; rsp_ill=1, rsp_data=0 one cycle after accept.
//  - Timeout: custom-1 op, stub never asserts oval -> ise_val high exactly MAX_WAIT=4 cycles; then rsp_ill=1.
//  - Backpressure/back-to-back: hold rsp_rdy=0 5 cycles -> rsp_* stable and req_rdy=0; then rsp_rdy=1 with req_val=1 -> new op accepted that cycle.
//  - Reset mid-op: ise_rst=0 while in ISSUE -> next cycle all outputs 0, state IDLE; the dropped op never yields rsp_val.
//  - With XALU_ISE_PERF_EN: 3 good ops + 2 illegal -> perf_ops=3, perf_ill=2; after reset both 0.

Source files
------------

// File: rtl/xalu_ise_pkg.sv
// Shared constants for the custom-0..3 ISE issue path: custom indices, opcodes, FSM encoding.
// Pure declarations; no latency and no backpressure of its own.
package xalu_ise_pkg;

   localparam logic [1:0] CUSTOM_0 = 2'd0;
   localparam logic [1:0] CUSTOM_1 = 2'd1;
   localparam logic [1:0] CUSTOM_2 = 2'd2;
   localparam logic [1:0] CUSTOM_3 = 2'd3;

   localparam logic [6:0] OPC_CUSTOM_0 = 7'h0B;
   localparam logic [6:0] OPC_CUSTOM_1 = 7'h2B;
   localparam logic [6:0] OPC_CUSTOM_2 = 7'h5B;
   localparam logic [6:0] OPC_CUSTOM_3 = 7'h7B;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_ISSUE = ST_ISSUE,
      S_RESP  = ST_RESP
   } state_e;

endpackage

// File: rtl/xalu_ise_dec.sv
// Combinational decode of a RISC-V word into {is_custom, fn, imm, rd} for the ISE port.
// Zero latency; no flow control.
module xalu_ise_dec
   import xalu_ise_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        is_custom_o,
   output logic [4:0]  fn_o,
   output logic [6:0]  imm_o,
   output logic [4:0]  rd_o
);

   logic [1:0] idx;
   logic       unused_bits;

   always_comb begin
      is_custom_o = 1'b1;
      idx         = CUSTOM_0;
      case (instr_i[6:0])
         OPC_CUSTOM_0: idx = CUSTOM_0;
         OPC_CUSTOM_1: idx = CUSTOM_1;
         OPC_CUSTOM_2: idx = CUSTOM_2;
         OPC_CUSTOM_3: idx = CUSTOM_3;
         default:      is_custom_o = 1'b0;
      endcase
   end

   assign fn_o  = {instr_i[14:12], idx};
   assign imm_o = instr_i[31:25];
   assign rd_o  = instr_i[11:7];

   // Register-source fields arrive as operand values, so their index bits are not needed here.
   assign unused_bits = ^instr_i[24:15];

endmodule

// File: rtl/xalu_ise_issue.sv
// ISE issue/writeback FSM: accept -> ise_val next cycle -> rsp_val one cycle after ise_oval (timeout -> illegal).
// req_rdy only in IDLE or when RESP drains; rsp_* held until rsp_rdy. Optional perf counters: XALU_ISE_PERF_EN.
module xalu_ise_issue
   import xalu_ise_pkg::*;
#(
   parameter int MAX_WAIT = 4
`ifdef XALU_ISE_PERF_EN
  ,parameter int CNT_W    = 32
`endif
)(
   input  logic        ise_clk,
   input  logic        ise_rst,
   input  logic        req_val,
   output logic        req_rdy,
   input  logic [31:0] req_instr,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic        rsp_val,
   input  logic        rsp_rdy,
   output logic [4:0]  rsp_rd,
   output logic [31:0] rsp_data,
   output logic        rsp_ill,
   output logic        ise_val,
   output logic [4:0]  ise_fn,
   output logic [6:0]  ise_imm,
   output logic [31:0] ise_in1,
   output logic [31:0] ise_in2,
   input  logic        ise_oval,
   input  logic [31:0] ise_out
`ifdef XALU_ISE_PERF_EN
  ,output logic [CNT_W-1:0] perf_ops
  ,output logic [CNT_W-1:0] perf_ill
`endif
);

   localparam int              WW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WW-1:0]   WAIT_LAST = WW'(MAX_WAIT - 1);

   state_e        state_q;
   logic [WW-1:0] wait_q;
   logic          rsp_val_q, rsp_ill_q, ise_val_q;
   logic [4:0]    rsp_rd_q, ise_fn_q;
   logic [6:0]    ise_imm_q;
   logic [31:0]   rsp_data_q, ise_in1_q, ise_in2_q;

   logic          dec_custom;
   logic [4:0]    dec_fn, dec_rd;
   logic [6:0]    dec_imm;
   logic          accept, done_ok, timeout;

   xalu_ise_dec u_dec (
      .instr_i     (req_instr),
      .is_custom_o (dec_custom),
      .fn_o        (dec_fn),
      .imm_o       (dec_imm),
      .rd_o        (dec_rd)
   );

   assign req_rdy = (state_q == S_IDLE) | ((state_q == S_RESP) & rsp_rdy);
   assign accept  = req_val & req_rdy;
   assign done_ok = (state_q == S_ISSUE) & ise_oval;
   // A result arriving on the last wait cycle beats the timeout.
   assign timeout = (state_q == S_ISSUE) & ~ise_oval & (wait_q == WAIT_LAST);

   always_ff @(posedge ise_clk) begin
      if (!ise_rst) begin
         state_q    <= S_IDLE;
         wait_q     <= '0;
         rsp_val_q  <= 1'b0;
         rsp_ill_q  <= 1'b0;
         rsp_rd_q   <= '0;
         rsp_data_q <= '0;
         ise_val_q  <= 1'b0;
         ise_fn_q   <= '0;
         ise_imm_q  <= '0;
         ise_in1_q  <= '0;
         ise_in2_q  <= '0;
      end else if (accept) begin
         ise_in1_q <= req_rs1;
         ise_in2_q <= req_rs2;
         ise_fn_q  <= dec_fn;
         ise_imm_q <= dec_imm;
         rsp_rd_q  <= dec_rd;
         wait_q    <= '0;
         if (dec_custom) begin
            state_q   <= S_ISSUE;
            ise_val_q <= 1'b1;
            rsp_val_q <= 1'b0;
            rsp_ill_q <= 1'b0;
         end else begin
            state_q    <= S_RESP;
            rsp_val_q  <= 1'b1;
            rsp_ill_q  <= 1'b1;
            rsp_data_q <= '0;
         end
      end else begin
         case (state_q)
            S_ISSUE: begin
               if (done_ok) begin
                  state_q    <= S_RESP;
                  ise_val_q  <= 1'b0;
                  rsp_val_q  <= 1'b1;
                  rsp_ill_q  <= 1'b0;
                  rsp_data_q <= ise_out;
               end else if (timeout) begin
                  state_q    <= S_RESP;
                  ise_val_q  <= 1'b0;
                  rsp_val_q  <= 1'b1;
                  rsp_ill_q  <= 1'b1;
                  rsp_data_q <= '0;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_rdy) begin
                  state_q   <= S_IDLE;
                  rsp_val_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_val  = rsp_val_q;
   assign rsp_ill  = rsp_ill_q;
   assign rsp_rd   = rsp_rd_q;
   assign rsp_data = rsp_data_q;
   assign ise_val  = ise_val_q;
   assign ise_fn   = ise_fn_q;
   assign ise_imm  = ise_imm_q;
   assign ise_in1  = ise_in1_q;
   assign ise_in2  = ise_in2_q;

`ifdef XALU_ISE_PERF_EN
   logic [CNT_W-1:0] perf_ops_q, perf_ill_q;

   always_ff @(posedge ise_clk) begin
      if (!ise_rst) begin
         perf_ops_q <= '0;
         perf_ill_q <= '0;
      end else begin
         if (done_ok)
            perf_ops_q <= perf_ops_q + 1'b1;
         if ((accept & ~dec_custom) | timeout)
            perf_ill_q <= perf_ill_q + 1'b1;
      end
   end

   assign perf_ops = perf_ops_q;
   assign perf_ill = perf_ill_q;
`endif

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Directed bench for xalu_ise_issue: happy path, illegal opcode, timeout, backpressure, reset mid-op.
module tb_xalu_ise_issue;

   localparam logic [31:0] I_HAPPY = 32'h4A00050B;
   localparam logic [31:0] I_ADD   = 32'h00B50533;
   localparam logic [31:0] I_C1    = {7'h11, 5'd2, 5'd1, 3'b011, 5'd5, 7'h2B};
   localparam logic [31:0] I_C2    = {7'h7F, 5'd0, 5'd0, 3'b000, 5'd0, 7'h5B};
   localparam logic [31:0] I_C3    = {7'h01, 5'd3, 5'd4, 3'b101, 5'd7, 7'h7B};

   logic        ise_clk = 1'b0;
   logic        ise_rst, req_val, rsp_rdy, stub_auto, stub_force;
   logic [31:0] req_instr, req_rs1, req_rs2, ise_out;
   logic        req_rdy, rsp_val, rsp_ill, ise_val, ise_oval;
   logic [4:0]  rsp_rd, ise_fn;
   logic [6:0]  ise_imm;
   logic [31:0] rsp_data, ise_in1, ise_in2;
`ifdef XALU_ISE_PERF_EN
   logic [31:0] perf_ops, perf_ill;
`endif

   int n_pass = 0;
   int n_tot  = 0;
   int n_fail = 0;
   int hi;
   int seen;

   always #5 ise_clk = ~ise_clk;

   // Stub ISE: answers in the same cycle as ise_val when auto, or on demand when forced.
   assign ise_oval = (stub_auto & ise_val) | stub_force;

   xalu_ise_issue dut (
      .ise_clk   (ise_clk),
      .ise_rst   (ise_rst),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .req_instr (req_instr),
      .req_rs1   (req_rs1),
      .req_rs2   (req_rs2),
      .rsp_val   (rsp_val),
      .rsp_rdy   (rsp_rdy),
      .rsp_rd    (rsp_rd),
      .rsp_data  (rsp_data),
      .rsp_ill   (rsp_ill),
      .ise_val   (ise_val),
      .ise_fn    (ise_fn),
      .ise_imm   (ise_imm),
      .ise_in1   (ise_in1),
      .ise_in2   (ise_in2),
      .ise_oval  (ise_oval),
      .ise_out   (ise_out)
`ifdef XALU_ISE_PERF_EN
     ,.perf_ops  (perf_ops)
     ,.perf_ill  (perf_ill)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ise_clk);
      #1;
   endtask

   task automatic do_op(input logic [31:0] ins, input logic exp_ill, input logic [31:0] exp_dat);
      int n = 0;
      req_instr = ins;
      req_val   = 1'b1;
      rsp_rdy   = 1'b0;
      step();
      req_val = 1'b0;
      while (!rsp_val && n < 10) begin
         step();
         n++;
      end
      chk("op_rsp_val", rsp_val, 1);
      chk("op_rsp_ill", rsp_ill, exp_ill);
      chk("op_rsp_data", rsp_data, exp_dat);
      rsp_rdy = 1'b1;
      step();
      rsp_rdy = 1'b0;
   endtask

   initial begin
      ise_rst = 1'b0; req_val = 1'b0; rsp_rdy = 1'b0;
      stub_auto = 1'b0; stub_force = 1'b0;
      req_instr = '0; req_rs1 = '0; req_rs2 = '0; ise_out = 32'hDEADBEEF;
      repeat (2) step();
      chk("rst_rsp_val", rsp_val, 0);
      chk("rst_ise_val", ise_val, 0);
      chk("rst_rsp_ill", rsp_ill, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_rd", rsp_rd, 0);
      chk("rst_ise_in1", ise_in1, 0);
      chk("rst_req_rdy", req_rdy, 1);
      ise_rst = 1'b1;

      // Happy path, custom-0
      stub_auto = 1'b1;
      req_instr = I_HAPPY; req_rs1 = 32'h12345678; req_rs2 = 32'h000000AA; req_val = 1'b1;
      #1 chk("happy_req_rdy", req_rdy, 1);
      step();
      req_val = 1'b0;
      chk("happy_ise_val", ise_val, 1);
      chk("happy_ise_fn", ise_fn, 5'b00000);
      chk("happy_ise_imm", ise_imm, 7'h25);
      chk("happy_ise_in1", ise_in1, 32'h12345678);
      chk("happy_ise_in2", ise_in2, 32'h000000AA);
      chk("happy_rsp_val_early", rsp_val, 0);
      step();
      chk("happy_ise_val_off", ise_val, 0);
      chk("happy_rsp_val", rsp_val, 1);
      chk("happy_rsp_rd", rsp_rd, 10);
      chk("happy_rsp_data", rsp_data, 32'hDEADBEEF);
      chk("happy_rsp_ill", rsp_ill, 0);

      // Backpressure; stray oval in RESP must not disturb the held response
      stub_auto = 1'b0; stub_force = 1'b1; ise_out = 32'h11111111;
      req_instr = I_ADD; req_val = 1'b1; rsp_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_rsp_val", rsp_val, 1);
         chk("bp_rsp_data", rsp_data, 32'hDEADBEEF);
         chk("bp_rsp_rd", rsp_rd, 10);
         chk("bp_req_rdy", req_rdy, 0);
      end
      stub_force = 1'b0; rsp_rdy = 1'b1;
      #1 chk("b2b_req_rdy", req_rdy, 1);
      step();
      req_val = 1'b0; rsp_rdy = 1'b0;
      chk("ill_rsp_val", rsp_val, 1);
      chk("ill_rsp_ill", rsp_ill, 1);
      chk("ill_rsp_data", rsp_data, 0);
      chk("ill_rsp_rd", rsp_rd, 10);
      chk("ill_ise_val", ise_val, 0);

      // Timeout on custom-1, accepted back-to-back
      req_instr = I_C1; req_rs1 = 32'h00000001; rsp_rdy = 1'b1; req_val = 1'b1;
      step();
      req_val = 1'b0; rsp_rdy = 1'b0;
      chk("to_ise_fn", ise_fn, 5'b01101);
      chk("to_ise_imm", ise_imm, 7'h11);
      chk("to_ise_in1", ise_in1, 32'h00000001);
      chk("to_rsp_val_early", rsp_val, 0);
      hi = ise_val ? 1 : 0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (ise_val) hi++;
      end
      chk("to_ise_val_cycles", hi, 4);
      chk("to_rsp_val", rsp_val, 1);
      chk("to_rsp_ill", rsp_ill, 1);
      chk("to_rsp_data", rsp_data, 0);
      chk("to_rsp_rd", rsp_rd, 5);

      // Result on the final wait cycle wins over the timeout; rd=x0 still answered
      ise_out = 32'hCAFEF00D;
      req_instr = I_C2; rsp_rdy = 1'b1; req_val = 1'b1;
      step();
      req_val = 1'b0; rsp_rdy = 1'b0;
      chk("last_ise_fn", ise_fn, 5'b00010);
      chk("last_ise_imm", ise_imm, 7'h7F);
      step();
      step();
      step();
      chk("last_ise_val", ise_val, 1);
      stub_force = 1'b1;
      step();
      stub_force = 1'b0;
      chk("last_rsp_val", rsp_val, 1);
      chk("last_rsp_ill", rsp_ill, 0);
      chk("last_rsp_data", rsp_data, 32'hCAFEF00D);
      chk("last_rsp_rd", rsp_rd, 0);

      // Reset while in ISSUE
      req_instr = I_C3; req_rs1 = 32'hA5A5A5A5; req_rs2 = 32'h5A5A5A5A; rsp_rdy = 1'b1; req_val = 1'b1;
      step();
      req_val = 1'b0; rsp_rdy = 1'b0;
      chk("mid_ise_val", ise_val, 1);
      chk("mid_ise_fn", ise_fn, 5'b10111);
      chk("mid_ise_in1", ise_in1, 32'hA5A5A5A5);
`ifdef XALU_ISE_PERF_EN
      chk("perf_ops_pre", perf_ops, 2);
      chk("perf_ill_pre", perf_ill, 2);
`endif
      ise_rst = 1'b0;
      step();
      chk("mrst_ise_val", ise_val, 0);
      chk("mrst_rsp_val", rsp_val, 0);
      chk("mrst_ise_fn", ise_fn, 0);
      chk("mrst_ise_imm", ise_imm, 0);
      chk("mrst_ise_in1", ise_in1, 0);
      chk("mrst_ise_in2", ise_in2, 0);
      chk("mrst_rsp_rd", rsp_rd, 0);
      chk("mrst_req_rdy", req_rdy, 1);
`ifdef XALU_ISE_PERF_EN
      chk("perf_ops_rst", perf_ops, 0);
      chk("perf_ill_rst", perf_ill, 0);
`endif
      ise_rst = 1'b1; stub_force = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rsp_val || ise_val) seen++;
      end
      stub_force = 1'b0;
      chk("mrst_dropped", seen, 0);

      // Three good ops and two illegal ones
      stub_auto = 1'b1; ise_out = 32'h0BADF00D;
      do_op(I_HAPPY, 1'b0, 32'h0BADF00D);
      do_op(I_ADD,   1'b1, 32'h0);
      do_op(I_C1,    1'b0, 32'h0BADF00D);
      do_op(I_C3,    1'b0, 32'h0BADF00D);
      do_op(I_ADD,   1'b1, 32'h0);
`ifdef XALU_ISE_PERF_EN
      chk("perf_ops", perf_ops, 3);
      chk("perf_ill", perf_ill, 2);
      ise_rst = 1'b0;
      step();
      ise_rst = 1'b1;
      chk("perf_ops_clr", perf_ops, 0);
      chk("perf_ill_clr", perf_ill, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
